lsu_dmem_master: RTL

LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

---
 rtl/rv_pkg.sv | 44 ++++
 rtl/lsu_load_ext.sv | 41 ++++
 rtl/lsu_dmem_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared types for the load/store unit data-memory master.
//   mem_op_sz_e     : access size encoding (BYTE, HWORD, WORD; 2'd3 is undefined)
//   lsu_state_e     : LSU master FSM states (SPLIT only with LSU_MISALIGN_SPLIT_EN)
//   mem_size_nbytes : byte count of an access size, 0 for an undefined size
// Configuration macro: LSU_MISALIGN_SPLIT_EN
// ---------------------------------------------------------------------------
package rv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HWORD = 2'd1,
        MEM_WORD  = 2'd2
    } mem_op_sz_e;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_SPLIT  = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_e;
`else
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd3
    } lsu_state_e;
`endif

    // A zero byte count marks an undefined size; callers treat it as a fault.
    function automatic logic [2:0] mem_size_nbytes(input mem_op_sz_e size);
        logic [2:0] nbytes;
        case (size)
            MEM_BYTE:  nbytes = 3'd1;
            MEM_HWORD: nbytes = 3'd2;
            MEM_WORD:  nbytes = 3'd4;
            default:   nbytes = 3'd0;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// ---------------------------------------------------------------------------
// lsu_load_ext
// Combinational size/sign extension of LSB-aligned load data.
//   data        : raw load data, valid bytes in the low lanes
//   size        : access size selecting how many low bytes are kept
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   ext         : extended 32-bit result
// ---------------------------------------------------------------------------
module lsu_load_ext
    import rv_pkg::*;
(
    input  logic [31:0] data,
    input  mem_op_sz_e  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    logic sign_s;

    // Select kept bytes and fill the upper bits with zero or the sign bit
    always_comb begin
        sign_s = 1'b0;
        case (size)
            MEM_BYTE: begin
                sign_s = data[7] & ~is_unsigned;
                ext    = {{24{sign_s}}, data[7:0]};
            end
            MEM_HWORD: begin
                sign_s = data[15] & ~is_unsigned;
                ext    = {{16{sign_s}}, data[15:0]};
            end
            MEM_WORD: begin
                ext = data;
            end
            default: begin
                ext = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// lsu_dmem_master
// Bridges a pipeline load/store request to a single-port data memory with
// combinational reads and edge-committed writes. Requests are range-checked
// against MemBytes; misaligned requests are either split into byte accesses
// (LSU_MISALIGN_SPLIT_EN defined) or reported back as misaligned.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   request : i_req_valid/o_req_ready, i_req_we, i_req_addr, i_req_wdata,
//             i_req_size, i_req_unsigned
//   response: o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_fault,
//             o_rsp_misaligned (all registered)
//   memory  : o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size
//             (all registered), i_mem_rdata
// Configuration macro: LSU_MISALIGN_SPLIT_EN
// ---------------------------------------------------------------------------
module lsu_dmem_master
    import rv_pkg::*;
#(
    parameter int unsigned MemBytes = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  mem_op_sz_e  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault,
    output logic        o_rsp_misaligned,
    output logic        o_mem_we,
    output logic        o_mem_re,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output mem_op_sz_e  o_mem_size,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [32:0] MEM_LIMIT = 33'(MemBytes);

    lsu_state_e  state_r, state_next_s;
    logic        capture_s;
    logic        req_we_r;
    mem_op_sz_e  req_size_r;
    logic        req_unsigned_r;

    logic        rsp_valid_r, rsp_valid_next_s;
    logic        rsp_fault_r, rsp_fault_next_s;
    logic        rsp_mis_r, rsp_mis_next_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_next_s;

    logic        mem_we_r, mem_we_next_s;
    logic        mem_re_r, mem_re_next_s;
    logic [31:0] mem_addr_r, mem_addr_next_s;
    logic [31:0] mem_wdata_r, mem_wdata_next_s;
    mem_op_sz_e  mem_size_r, mem_size_next_s;

    logic [2:0]  in_nbytes_s;
    logic [32:0] in_last_s;
    logic        in_fault_s;
    logic        in_misaligned_s;

    logic [31:0] load_word_s;
    logic [31:0] load_ext_s;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] req_addr_r;
    logic [31:0] req_wdata_r;
    logic [1:0]  cnt_r, cnt_next_s;
    logic [31:0] buf_r, buf_next_s;
    logic [31:0] split_word_s;
    logic [2:0]  req_nbytes_s;
`endif

    // Range fault (33-bit, no wrap) and alignment of the incoming request
    always_comb begin
        in_nbytes_s = mem_size_nbytes(i_req_size);
        in_last_s   = {1'b0, i_req_addr} + {30'd0, in_nbytes_s} - 33'd1;
        if (in_nbytes_s == 3'd0) begin
            in_fault_s = 1'b1;
        end else begin
            in_fault_s = (in_last_s >= MEM_LIMIT);
        end
        case (i_req_size)
            MEM_HWORD: in_misaligned_s = i_req_addr[0];
            MEM_WORD:  in_misaligned_s = (i_req_addr[1:0] != 2'd0);
            default:   in_misaligned_s = 1'b0;
        endcase
    end

    // Word presented to the extender: live memory data, or the split buffer
    // with the byte arriving in this cycle merged in
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        req_nbytes_s = mem_size_nbytes(req_size_r);
        split_word_s = buf_r;
        split_word_s[{cnt_r, 3'b000} +: 8] = i_mem_rdata[7:0];
        if (state_r == LSU_SPLIT) begin
            load_word_s = split_word_s;
        end else begin
            load_word_s = i_mem_rdata;
        end
`else
        load_word_s = i_mem_rdata;
`endif
    end

    lsu_load_ext u_load_ext (
        .data        (load_word_s),
        .size        (req_size_r),
        .is_unsigned (req_unsigned_r),
        .ext         (load_ext_s)
    );

    // Next state plus next values of the registered response and memory port.
    // Memory outputs are computed one cycle ahead so they are registered and
    // still valid for exactly the ACCESS/SPLIT cycle they belong to.
    always_comb begin
        state_next_s     = state_r;
        capture_s        = 1'b0;
        rsp_valid_next_s = rsp_valid_r;
        rsp_fault_next_s = rsp_fault_r;
        rsp_mis_next_s   = rsp_mis_r;
        rsp_rdata_next_s = rsp_rdata_r;
        mem_we_next_s    = 1'b0;
        mem_re_next_s    = 1'b0;
        mem_addr_next_s  = 32'd0;
        mem_wdata_next_s = 32'd0;
        mem_size_next_s  = MEM_BYTE;
`ifdef LSU_MISALIGN_SPLIT_EN
        cnt_next_s       = cnt_r;
        buf_next_s       = buf_r;
`endif
        case (state_r)
            LSU_IDLE: begin
                if (i_req_valid) begin
                    capture_s = 1'b1;
                    if (in_fault_s) begin
                        // Fault wins over misalignment and blocks any access
                        state_next_s     = LSU_RESP;
                        rsp_valid_next_s = 1'b1;
                        rsp_fault_next_s = 1'b1;
                        rsp_mis_next_s   = 1'b0;
                        rsp_rdata_next_s = 32'd0;
                    end else if (in_misaligned_s) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        state_next_s     = LSU_SPLIT;
                        cnt_next_s       = 2'd0;
                        buf_next_s       = 32'd0;
                        mem_we_next_s    = i_req_we;
                        mem_re_next_s    = ~i_req_we;
                        mem_addr_next_s  = i_req_addr;
                        mem_wdata_next_s = {24'd0, i_req_wdata[7:0]};
                        mem_size_next_s  = MEM_BYTE;
`else
                        state_next_s     = LSU_RESP;
                        rsp_valid_next_s = 1'b1;
                        rsp_fault_next_s = 1'b0;
                        rsp_mis_next_s   = 1'b1;
                        rsp_rdata_next_s = 32'd0;
`endif
                    end else begin
                        state_next_s     = LSU_ACCESS;
                        mem_we_next_s    = i_req_we;
                        mem_re_next_s    = ~i_req_we;
                        mem_addr_next_s  = i_req_addr;
                        mem_wdata_next_s = i_req_wdata;
                        mem_size_next_s  = i_req_size;
                    end
                end else begin
                    state_next_s = LSU_IDLE;
                end
            end
            LSU_ACCESS: begin
                state_next_s     = LSU_RESP;
                rsp_valid_next_s = 1'b1;
                rsp_fault_next_s = 1'b0;
                rsp_mis_next_s   = 1'b0;
                rsp_rdata_next_s = req_we_r ? 32'd0 : load_ext_s;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            LSU_SPLIT: begin
                if (req_we_r) begin
                    buf_next_s = buf_r;
                end else begin
                    buf_next_s = split_word_s;
                end
                if ({1'b0, cnt_r} == (req_nbytes_s - 3'd1)) begin
                    state_next_s     = LSU_RESP;
                    rsp_valid_next_s = 1'b1;
                    rsp_fault_next_s = 1'b0;
                    rsp_mis_next_s   = 1'b0;
                    rsp_rdata_next_s = req_we_r ? 32'd0 : load_ext_s;
                end else begin
                    state_next_s     = LSU_SPLIT;
                    cnt_next_s       = cnt_r + 2'd1;
                    mem_we_next_s    = req_we_r;
                    mem_re_next_s    = ~req_we_r;
                    mem_addr_next_s  = req_addr_r + {30'd0, cnt_next_s};
                    mem_wdata_next_s = {24'd0, req_wdata_r[{cnt_next_s, 3'b000} +: 8]};
                    mem_size_next_s  = MEM_BYTE;
                end
            end
`endif
            LSU_RESP: begin
                if (i_rsp_ready) begin
                    state_next_s     = LSU_IDLE;
                    rsp_valid_next_s = 1'b0;
                    rsp_fault_next_s = 1'b0;
                    rsp_mis_next_s   = 1'b0;
                    rsp_rdata_next_s = 32'd0;
                end else begin
                    state_next_s = LSU_RESP;
                end
            end
            default: begin
                state_next_s     = LSU_IDLE;
                rsp_valid_next_s = 1'b0;
                rsp_fault_next_s = 1'b0;
                rsp_mis_next_s   = 1'b0;
                rsp_rdata_next_s = 32'd0;
            end
        endcase
    end

    // State, response and memory-port registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r     <= LSU_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= 1'b0;
            rsp_mis_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_size_r  <= MEM_BYTE;
        end else begin
            state_r     <= state_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            rsp_fault_r <= rsp_fault_next_s;
            rsp_mis_r   <= rsp_mis_next_s;
            rsp_rdata_r <= rsp_rdata_next_s;
            mem_we_r    <= mem_we_next_s;
            mem_re_r    <= mem_re_next_s;
            mem_addr_r  <= mem_addr_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            mem_size_r  <= mem_size_next_s;
        end
    end

    // Request capture on accept
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            req_we_r       <= 1'b0;
            req_size_r     <= MEM_BYTE;
            req_unsigned_r <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            req_addr_r     <= 32'd0;
            req_wdata_r    <= 32'd0;
`endif
        end else if (capture_s) begin
            req_we_r       <= i_req_we;
            req_size_r     <= i_req_size;
            req_unsigned_r <= i_req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
            req_addr_r     <= i_req_addr;
            req_wdata_r    <= i_req_wdata;
`endif
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Split byte counter and load assembly buffer
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_r <= 2'd0;
            buf_r <= 32'd0;
        end else begin
            cnt_r <= cnt_next_s;
            buf_r <= buf_next_s;
        end
    end
`endif

    assign o_req_ready      = (state_r == LSU_IDLE);
    assign o_rsp_valid      = rsp_valid_r;
    assign o_rsp_rdata      = rsp_rdata_r;
    assign o_rsp_fault      = rsp_fault_r;
    assign o_rsp_misaligned = rsp_mis_r;
    assign o_mem_we         = mem_we_r;
    assign o_mem_re         = mem_re_r;
    assign o_mem_addr       = mem_addr_r;
    assign o_mem_wdata      = mem_wdata_r;
    assign o_mem_size       = mem_size_r;

endmodule
